mips_alu_seq: RTL
=================

# mips_alu_seq

Parametrised sequential successor to the combinational MIPS execute-stage ALU. Single-cycle operations (add/sub, logic, set-less-than, barrel shifts, count-leading-zeros) return one cycle after acceptance. Iterative multiply/divide instructions write the HI/LO register pair. A valid/ready handshake lets the pipeline stall EX while an iterative operation is in flight.

## Interface
Parameters:
- WIDTH, 32, datapath width; power of two, 8..64.
- SHW, $clog2(WIDTH), shift-amount width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, A SRA, B CLZ, C MULT, D MULTU, E DIV, F DIVU.
- a, b  in  WIDTH  operands; shifts shift b, CLZ counts a.
- shamt  in  SHW  shift amount.
- cancel  in  1  synchronous abort of an in-flight iterative op.
- out_valid  out  1  one-cycle pulse, result/flags valid.
- result  out  WIDTH  registered result; LO for ops C..F.
- zero, less, overflow, dbz  out  1  registered flags.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Request is accepted on a clock edge where in_valid && in_ready. Inputs are sampled only at acceptance.
- States: IDLE, ITER, FIX. in_ready = (state==IDLE).
- Ops 0..B: computed combinationally and registered at the acceptance edge; state stays IDLE.
- ADD/SUB: WIDTH-bit two's complement, wrap-around. overflow = signed overflow. zero = (result==0).
- SLT/SLTU: result = {0..0, less}. less is signed/unsigned a<b. For all other ops, less = signed a<b computed from a-b with overflow correction.
- SLL/SRL/SRA: b shifted by shamt; SRA sign-fills.
- CLZ: leading zeros of a, 0..WIDTH; a==0 gives WIDTH.
- MULT/MULTU: IDLE -> ITER on acceptance. Signed forms take operand magnitudes.
  - ITER runs WIDTH shift-add steps, then goes to FIX.
  - FIX applies sign correction and writes {hi,lo} = 2*WIDTH-bit product, then returns to IDLE.
- DIV/DIVU: same flow using WIDTH restoring-division steps.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a). lo = quotient, hi = remainder.
  - MIN / -1 gives lo = MIN, hi = 0.
- Divide by zero: the ITER steps still run. FIX writes lo = all ones, hi = a, dbz = 1.
- dbz = 0 for all other ops. overflow = 0 for ops other than ADD/SUB.
- cancel while state != IDLE: return to IDLE next edge. hi/lo are unchanged and no out_valid is produced. cancel in IDLE is ignored, and an acceptance in the same cycle proceeds.
- Reset: state IDLE; out_valid, result, all flags, hi, lo = 0. in_ready = 1 once rst deasserts. Reset mid-iteration discards the operation.

## Timing
- Single-cycle ops: accepted at edge N, out_valid high for the cycle after edge N. Back-to-back acceptance every cycle is allowed.
- Iterative ops: accepted at edge N, out_valid high for the cycle after edge N+WIDTH+1, so latency is WIDTH+2 edges.
  - in_ready is low from edge N until the FIX->IDLE edge.
  - in_ready is high again in the out_valid cycle, so a new request can be accepted there.
- hi/lo update at the FIX edge, in the same cycle out_valid rises.
- out_valid never stays high two consecutive cycles for the same operation.
- Flags and result hold their last value when out_valid is low.

## Configuration
- ALU_DIV_EN defined: DIV/DIVU are implemented as above.
- ALU_DIV_EN undefined: no divider logic is built. DIV/DIVU complete as single-cycle ops with result = 0, dbz = 1, and hi/lo unchanged. MULT/MULTU are unaffected.

## Test plan
- WIDTH=32. ADD a=0x7FFFFFFF, b=1 -> next cycle: result=0x80000000, overflow=1, zero=0, out_valid=1. SUB a=5, b=5 -> result=0, zero=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1. SLTU same operands -> result=0. SRA b=0x80000000, shamt=31 -> 0xFFFFFFFF. CLZ a=0 -> 32. CLZ a=0x00010000 -> 15.
- MULT a=-3, b=7 -> in_ready low 33 cycles; out_valid at latency 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF^2 -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0. DIVU a=9, b=0 -> lo=0xFFFFFFFF, hi=9, dbz=1. Without ALU_DIV_EN: DIV completes in 1 cycle, dbz=1, hi/lo unchanged.
- Start MULT, assert cancel at cycle 10 -> no out_valid, hi/lo keep prior values, in_ready=1 next cycle. Repeat with rst asserted at cycle 10 -> all outputs 0 immediately.
- Issue ADD in the out_valid cycle of a MULT -> ADD accepted, its out_valid follows one cycle later. Back-to-back ADDs for 8 cycles -> 8 consecutive out_valid pulses with correct results.

Source files
------------

// File: rtl/mips_alu_seq.sv
// -----------------------------------------------------------------------------
// mips_alu_seq
//
// Sequential MIPS execute-stage ALU. Single-cycle operations (add/sub, logic,
// set-less-than, barrel shifts, count-leading-zeros) are registered at the
// acceptance edge. Multiply and divide run as WIDTH-step iterative operations
// and write the HI/LO register pair. A valid/ready handshake lets the pipeline
// stall EX while an iterative operation is in flight.
//
// Build option:
//   ALU_DIV_EN  defined   -> DIV/DIVU use the iterative restoring divider.
//               undefined -> no divider is built; DIV/DIVU finish in one
//                            cycle with result = 0, dbz = 1, HI/LO unchanged.
//
// Parameters:
//   WIDTH      datapath width, power of two, 8..64
//   SHW        shift-amount width, $clog2(WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operation request
//   in_ready   a request can be accepted this cycle
//   op         operation code (0 ADD .. F DIVU)
//   a, b       operands; shifts shift b, CLZ counts a
//   shamt      shift amount
//   cancel     abort an in-flight iterative operation
//   out_valid  one-cycle pulse, result and flags valid
//   result     registered result (LO for multiply/divide)
//   zero, less, overflow, dbz   registered flags
//   hi, lo     architectural HI/LO registers
// -----------------------------------------------------------------------------
module mips_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             cancel,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             less,
  output logic             overflow,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Operation codes
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOR   = 4'h5;
  localparam logic [3:0] OP_SLT   = 4'h6;
  localparam logic [3:0] OP_SLTU  = 4'h7;
  localparam logic [3:0] OP_SLL   = 4'h8;
  localparam logic [3:0] OP_SRL   = 4'h9;
  localparam logic [3:0] OP_SRA   = 4'hA;
  localparam logic [3:0] OP_CLZ   = 4'hB;
  localparam logic [3:0] OP_MULT  = 4'hC;
  localparam logic [3:0] OP_MULTU = 4'hD;
  localparam logic [3:0] OP_DIV   = 4'hE;
  localparam logic [3:0] OP_DIVU  = 4'hF;

  // Control states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]     state;
  logic [SHW-1:0] cnt;

  logic accept;
  logic start_iter;
  logic op_is_mul;
  logic op_is_div;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_DIV_EN
  assign op_is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
  assign op_is_div = 1'b0;
`endif
  assign start_iter = accept && (op_is_mul || op_is_div);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf_add;
  logic             ovf_sub;
  logic             lt_s;
  logic             lt_u;
  logic [SHW:0]     clz;

  assign sum  = a + b;
  assign diff = a - b;
  assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Sign of a-b is wrong exactly when the subtraction overflowed.
  assign lt_s = diff[WIDTH-1] ^ ovf_sub;
  assign lt_u = a < b;

  // The highest set bit is visited last, so it sets the final count.
  always_comb begin
    clz = (SHW+1)'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a[i]) clz = (SHW+1)'(WIDTH - 1 - i);
    end
  end

  logic [WIDTH-1:0] sc_result;
  logic             sc_ovf;
  logic             sc_dbz;
  logic             sc_less;

  // NOTE: every output of a combinational block gets a default before the
  // case statement so that no path leaves it unassigned (which would infer a latch).
  always_comb begin
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_dbz    = 1'b0;
    sc_less   = lt_s;
    case (op)
      OP_ADD:  begin sc_result = sum;  sc_ovf = ovf_add; end
      OP_SUB:  begin sc_result = diff; sc_ovf = ovf_sub; end
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_NOR:  sc_result = ~(a | b);
      OP_SLT:  sc_result = WIDTH'(lt_s);
      OP_SLTU: begin sc_result = WIDTH'(lt_u); sc_less = lt_u; end
      OP_SLL:  sc_result = b << shamt;
      OP_SRL:  sc_result = b >> shamt;
      OP_SRA:  sc_result = $signed(b) >>> shamt;
      OP_CLZ:  sc_result = WIDTH'(clz);
`ifndef ALU_DIV_EN
      // No divider: report divide-unavailable as a one-cycle dbz completion.
      OP_DIV, OP_DIVU: sc_dbz = 1'b1;
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide datapath
  // ---------------------------------------------------------------------------
  // Signed forms (C, E) have op[0] clear; iterate on magnitudes and fix the
  // sign afterwards.
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed && a[WIDTH-1];
  assign b_neg     = op_signed && b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // acc holds {upper, lower}. Multiply: upper = partial product, lower = the
  // multiplier being shifted out. Divide: upper = remainder, lower = dividend
  // shifting out while quotient bits shift in.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     mul_sum;
  logic               less_q;
  logic               neg_lo_q;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);

`ifdef ALU_DIV_EN
  logic             is_div_q;
  logic             neg_hi_q;
  logic             dbz_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;

  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign rem_sub = rem_sh - {1'b0, mcand};
`endif

  always_comb begin
    acc_step = {mul_sum, acc[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    if (is_div_q) begin
      // Restoring step: keep the subtraction only if it did not borrow.
      if (rem_sub[WIDTH]) acc_step = {acc[2*WIDTH-2:0], 1'b0};
      else                acc_step = {rem_sub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // NOTE: the iteration registers are fully loaded at acceptance and only read
  // while an operation is in flight, so they carry no reset.
  always_ff @(posedge clk) begin
    if (start_iter) begin
      less_q   <= lt_s;
      neg_lo_q <= a_neg ^ b_neg;
      if (op_is_mul) begin
        mcand <= a_mag;
        acc   <= {{WIDTH{1'b0}}, b_mag};
      end else begin
        mcand <= b_mag;
        acc   <= {{WIDTH{1'b0}}, a_mag};
      end
`ifdef ALU_DIV_EN
      is_div_q <= op_is_div;
      neg_hi_q <= a_neg;
      dbz_q    <= (b == '0);
      a_q      <= a;
`endif
    end else if (state == S_ITER) begin
      acc <= acc_step;
    end
  end

  // Values written to HI/LO in the FIX state.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;
  logic               fix_dbz;

  assign prod_fix = neg_lo_q ? -acc : acc;

  always_comb begin
    fix_hi  = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo  = prod_fix[WIDTH-1:0];
    fix_dbz = 1'b0;
`ifdef ALU_DIV_EN
    if (is_div_q) begin
      if (dbz_q) begin
        fix_hi  = a_q;
        fix_lo  = '1;
        fix_dbz = 1'b1;
      end else begin
        // Quotient takes sign(a)^sign(b); remainder takes sign(a).
        fix_lo = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Control and architectural outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      less      <= 1'b0;
      overflow  <= 1'b0;
      dbz       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          // cancel is ignored here; an acceptance in the same cycle proceeds.
          if (accept) begin
            if (start_iter) begin
              state <= S_ITER;
              cnt   <= SHW'(WIDTH - 1);
            end else begin
              out_valid <= 1'b1;
              result    <= sc_result;
              zero      <= (sc_result == '0);
              less      <= sc_less;
              overflow  <= sc_ovf;
              dbz       <= sc_dbz;
            end
          end
        end
        S_ITER: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - SHW'(1);
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!cancel) begin
            out_valid <= 1'b1;
            result    <= fix_lo;
            hi        <= fix_hi;
            lo        <= fix_lo;
            zero      <= (fix_lo == '0);
            less      <= less_q;
            overflow  <= 1'b0;
            dbz       <= fix_dbz;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
